grf_mp: RTL and testbench
=========================

# grf_mp

Parametrised general-purpose register file for the pipelined MIPS core, replacing the fixed 32x32 two-read/one-write file. It has a configurable number of registers, data width and read-port count. It provides two prioritised write ports with optional same-cycle write-to-read bypass. It also keeps a per-register pending-write scoreboard that the decode stage uses to detect RAW hazards and to gate issue.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: address width; the file holds `2**ADDR_W` registers, with register 0 hardwired to zero.
- `NRD`, default 2: number of read ports, legal range 1..4.
- `BYPASS`, default 1: 1 means a same-cycle write is forwarded to the reads; 0 means reads return stored contents only.
- `clk` in, 1 bit: the single clock; all state updates on the rising edge.
- `reset` in, 1 bit: asynchronous, active-low reset.
- `rd_addr` in, `NRD*ADDR_W` bits: read addresses; port k uses bits `[k*ADDR_W +: ADDR_W]`.
- `rd_data` out, `NRD*DATA_W` bits: read data, packed the same way as `rd_addr`.
- `rd_busy` out, `NRD` bits: high when the addressed register has an outstanding pending write.
- `wr0_en`, `wr1_en` in, 1 bit each: write enables. Port 1 has priority over port 0.
- `wr0_addr`, `wr1_addr` in, `ADDR_W` bits each: write addresses.
- `wr0_data`, `wr1_data` in, `DATA_W` bits each: write data.
- `wr0_clr`, `wr1_clr` in, 1 bit each: this write retires one scoreboard entry. Only meaningful together with the matching `wrN_en`.
- `iss_en` in, 1 bit: the decode stage issues an instruction that will write `iss_addr`.
- `iss_addr` in, `ADDR_W` bits: destination register of the issued instruction.
- `iss_ready` out, 1 bit: the scoreboard can accept an issue to `iss_addr`.

## Operation
- **Storage:** `2**ADDR_W` x `DATA_W` flops. Register 0 always reads 0, is never written and is never busy.
- **Writes:** committed at the rising edge when `wrN_en` is high and `wrN_addr` is not 0.
  - If both ports write the same address, `wr1_data` is stored.
- **Reads:** combinational. `rd_data[k]` is chosen in this order:
  - 0, if `rd_addr[k]` is 0;
  - else, if `BYPASS`=1 and `wr1_en` is high with `wr1_addr` equal to `rd_addr[k]`: `wr1_data`;
  - else, if `BYPASS`=1 and `wr0_en` is high with `wr0_addr` equal to `rd_addr[k]`: `wr0_data`;
  - else the stored value.
- **Scoreboard:** one 2-bit pending counter per register `cnt[r]`, range 0..3.
  - Increment: +1 when `iss_en` is high, `iss_ready` is high and `iss_addr` is not 0.
  - Decrement: -1 for each port with `wrN_en`, `wrN_clr` high and `wrN_addr` equal to r. Two clears to the same address give -2.
  - Net update: `cnt_next = clamp(cnt + inc - dec, 0, 3)`.
  - A decrement below 0 clamps to 0. This is a protocol error and is flagged by a simulation-only assertion.
- **`rd_busy[k]`:**
  - With `BYPASS`=1: `(cnt[rd_addr[k]] - same-cycle decrements to that address, floored at 0) != 0`.
  - With `BYPASS`=0: `cnt[rd_addr[k]] != 0`.
  - Always 0 when `rd_addr[k]` is 0.
- **`iss_ready`:**
  - High when `iss_addr` is 0.
  - Otherwise high when `cnt[iss_addr] - same-cycle decrements < 3`.
  - An issue presented with `iss_ready` low is ignored, with no state change.

## Timing
- **Reset:** while `reset` is low, asynchronously and immediately:
  - all registers and all counters are 0;
  - hence `rd_data` is all 0, `rd_busy` is all 0 and `iss_ready` is 1.
  - Writes, issues and clears presented during reset are discarded.
  - Deassertion takes effect at the first rising edge where `reset` is sampled high.
- **Write latency:** 1 cycle to storage. With `BYPASS`=1 the read result is visible in the same cycle; with `BYPASS`=0 it is visible in the cycle after the edge.
- **Scoreboard latency:** an issue at edge n makes `rd_busy` high from cycle n+1. A clear with `BYPASS`=1 drops `rd_busy` in the same cycle.
- **Simultaneous issue and clear on the same register:** the counter is unchanged.
- **Reset mid-operation:** pending counts are lost. The pipeline is flushed together with the file.
- No output is registered; all outputs are combinational from state plus the current inputs.

## Test plan
- **Reset:** drive `reset`=0 mid-cycle after loading r5=0x1234 -> `rd_data` for r5 reads 0 immediately, `rd_busy`=0 and `iss_ready`=1.
- **Bypass priority:**
  - Stimulus: `wr0` writes r3=0xAAAA0000 and `wr1` writes r3=0x5555FFFF in the same cycle, with `rd_addr[0]`=3 and `BYPASS`=1.
  - Response: `rd_data[0]`=0x5555FFFF in that cycle, and storage holds 0x5555FFFF afterwards.
  - Repeat with `BYPASS`=0: the old value is read in that cycle and 0x5555FFFF in the next.
- **Register zero:** write 0xDEADBEEF to r0 and issue to r0 -> reads return 0, `rd_busy`=0 and `iss_ready` stays 1.
- **Scoreboard saturation:**
  - Stimulus: issue to r7 four times.
  - Response: `iss_ready` goes low after the third issue and the fourth issue is ignored.
  - Then clear r7 once: `iss_ready` rises in the same cycle, and `cnt` goes 3 -> 2.
- **Simultaneous events:** issue to r9 (`cnt`=1) while `wr0` clears r9 -> `cnt` stays 1. Both ports clearing r9 while `cnt`=2 -> `cnt`=0 and `rd_busy` is low in the same cycle.
- **Parametrisation:** build with `DATA_W`=64, `ADDR_W`=4 and `NRD`=4. Random writes, reads and issues checked against a reference model over 10k cycles give zero mismatches.

Source files
------------

// File: rtl/grf_mp.sv
// Register file with two prioritised write ports, optional write-to-read bypass and a pending-write scoreboard.
// Reads, rd_busy and iss_ready are combinational; writes land in 1 cycle; issue is gated only by iss_ready.
module grf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    wr0_en,
    input  logic [ADDR_W-1:0]       wr0_addr,
    input  logic [DATA_W-1:0]       wr0_data,
    input  logic                    wr0_clr,
    input  logic                    wr1_en,
    input  logic [ADDR_W-1:0]       wr1_addr,
    input  logic [DATA_W-1:0]       wr1_data,
    input  logic                    wr1_clr,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic                    iss_ready
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];
    logic [1:0]        cnt_q [NREG];
    logic [1:0]        cnt_d [NREG];
    logic [1:0]        dec   [NREG];
    logic              clr0;
    logic              clr1;
    logic              inc;
    logic [2:0]        sum;
    logic              uflow;

    // Pending count left after this cycle's retirements, floored at zero.
    function automatic logic [1:0] net_cnt(input logic [1:0] c, input logic [1:0] d);
        return (c > d) ? 2'(c - d) : 2'd0;
    endfunction

    assign clr0 = wr0_en & wr0_clr;
    assign clr1 = wr1_en & wr1_clr;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            dec[r] = 2'(clr0 && (wr0_addr == ADDR_W'(r))) + 2'(clr1 && (wr1_addr == ADDR_W'(r)));
        end
    end

    // A full counter can still accept an issue when a retirement lands in the same cycle.
    assign iss_ready = (iss_addr == '0) || (cnt_q[iss_addr] != 2'd3) || (dec[iss_addr] != 2'd0);

    always_comb begin
        inc   = 1'b0;
        sum   = 3'd0;
        uflow = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            inc = iss_en && iss_ready && (iss_addr == ADDR_W'(r));
            sum = {1'b0, cnt_q[r]} + {2'b00, inc};
            if (r == 0) begin
                cnt_d[r] = 2'd0;
            end else if (sum < {1'b0, dec[r]}) begin
                cnt_d[r] = 2'd0;
                uflow    = 1'b1;
            end else if ((sum - {1'b0, dec[r]}) > 3'd3) begin
                cnt_d[r] = 2'd3;
            end else begin
                cnt_d[r] = 2'(sum - {1'b0, dec[r]});
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            mem_d[r] = mem_q[r];
            if (r != 0) begin
                if (wr0_en && (wr0_addr == ADDR_W'(r))) mem_d[r] = wr0_data;
                if (wr1_en && (wr1_addr == ADDR_W'(r))) mem_d[r] = wr1_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
                cnt_q[r] <= 2'd0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= mem_d[r];
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;

        assign a = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            d = mem_q[a];
            if (BYPASS != 0) begin
                if (wr0_en && (wr0_addr == a)) d = wr0_data;
                if (wr1_en && (wr1_addr == a)) d = wr1_data;
            end
            if (a == '0) d = '0;
        end

        assign rd_data[k*DATA_W +: DATA_W] = d;
        assign rd_busy[k] = (a != '0) &&
                            ((BYPASS != 0) ? (net_cnt(cnt_q[a], dec[a]) != 2'd0) : (cnt_q[a] != 2'd0));
    end

    // Retiring more writes than were issued means the pipeline lost track of a destination.
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !uflow);

endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: bypassing and non-bypassing instances share stimulus; a queue-based scoreboard checks both.
module tb_grf_mp;
    localparam int DW   = 64;
    localparam int AW   = 4;
    localparam int NR   = 4;
    localparam int NREG = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data_a, rd_data_b;
    logic [NR-1:0]     busy_a, busy_b;
    logic              wr0_en, wr0_clr, wr1_en, wr1_clr, iss_en;
    logic [AW-1:0]     wr0_addr, wr1_addr, iss_addr;
    logic [DW-1:0]     wr0_data, wr1_data;
    logic              rdy_a, rdy_b;

    grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(busy_a),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_clr(wr0_clr),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_clr(wr1_clr),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(rdy_a));

    grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_clr(wr0_clr),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_clr(wr1_clr),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(rdy_b));

    typedef struct packed {
        logic [NR*DW-1:0] da;
        logic [NR*DW-1:0] db;
        logic [NR-1:0]    ba;
        logic [NR-1:0]    bb;
        logic             ra;
        logic             rb;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mem [NREG];
    int            cnt [NREG];
    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;

    function automatic int ndec(int a);
        int d = 0;
        if (wr0_en && wr0_clr && int'(wr0_addr) == a) d++;
        if (wr1_en && wr1_clr && int'(wr1_addr) == a) d++;
        return d;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   a;
        int   n;
        e = '0;
        e.ra = 1'b1;
        e.rb = 1'b1;
        if (reset) begin
            for (int k = 0; k < NR; k++) begin
                a = int'(rd_addr[k*AW +: AW]);
                if (a != 0) begin
                    e.db[k*DW +: DW] = mem[a];
                    if (wr1_en && int'(wr1_addr) == a)      e.da[k*DW +: DW] = wr1_data;
                    else if (wr0_en && int'(wr0_addr) == a) e.da[k*DW +: DW] = wr0_data;
                    else                                    e.da[k*DW +: DW] = mem[a];
                    n = cnt[a] - ndec(a);
                    e.ba[k] = (n > 0);
                    e.bb[k] = (cnt[a] != 0);
                end
            end
            if (iss_addr != 0) begin
                e.ra = (cnt[iss_addr] - ndec(int'(iss_addr))) < 3;
                e.rb = e.ra;
            end
        end
        return e;
    endfunction

    task automatic commit(input logic ready);
        int d[NREG];
        int n;
        for (int r = 0; r < NREG; r++) d[r] = ndec(r);
        if (wr0_en && wr0_addr != 0) mem[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) mem[wr1_addr] = wr1_data;
        for (int r = 1; r < NREG; r++) begin
            n = cnt[r] - d[r];
            if (iss_en && ready && int'(iss_addr) == r) n++;
            cnt[r] = (n < 0) ? 0 : (n > 3) ? 3 : n;
        end
    endtask

    task automatic tick();
        exp_t e;
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] = '0;
                cnt[r] = 0;
            end
        end
        e = predict();
        exp_q.push_back(e);
        @(posedge clk);
        if (reset) commit(e.ra);
        #1;
    endtask

    task automatic idle();
        wr0_en = 0; wr0_clr = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_clr = 0; wr1_addr = '0; wr1_data = '0;
        iss_en = 0; iss_addr = '0; rd_addr = '0;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic cmp(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, want);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 7));
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("rd_data_byp",     rd_data_a,               e.da);
                cmp("rd_data_nobyp",   rd_data_b,               e.db);
                cmp("rd_busy_byp",     {{(NR*DW-NR){1'b0}}, busy_a}, {{(NR*DW-NR){1'b0}}, e.ba});
                cmp("rd_busy_nobyp",   {{(NR*DW-NR){1'b0}}, busy_b}, {{(NR*DW-NR){1'b0}}, e.bb});
                cmp("iss_ready_byp",   {{(NR*DW-1){1'b0}}, rdy_a},   {{(NR*DW-1){1'b0}}, e.ra});
                cmp("iss_ready_nobyp", {{(NR*DW-1){1'b0}}, rdy_b},   {{(NR*DW-1){1'b0}}, e.rb});
            end
        end
    end

    initial begin
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b1;

        // load r5, then pull reset mid-cycle while reading it
        idle(); wr0_en = 1; wr0_addr = 5; wr0_data = 64'h1234; set_rd(0, 5); tick();
        idle(); set_rd(0, 5); tick();
        reset = 1'b0; tick();
        reset = 1'b1; tick();

        // both ports write r3 in the same cycle
        idle(); wr0_en = 1; wr0_addr = 3; wr0_data = 64'hAAAA0000;
        wr1_en = 1; wr1_addr = 3; wr1_data = 64'h5555FFFF; set_rd(0, 3); set_rd(2, 3); tick();
        idle(); set_rd(0, 3); tick();

        // register zero is immutable and never busy
        idle(); wr0_en = 1; wr0_addr = 0; wr0_data = 64'hDEADBEEF;
        wr1_en = 1; wr1_addr = 0; wr1_data = 64'hDEADBEEF; iss_en = 1; iss_addr = 0; tick();
        idle(); tick();

        // saturate r7, then retire one
        idle(); iss_en = 1; iss_addr = 7; set_rd(1, 7);
        repeat (4) tick();
        idle(); iss_addr = 7; set_rd(1, 7); wr1_en = 1; wr1_clr = 1; wr1_addr = 7; wr1_data = 64'h77; tick();
        idle(); iss_addr = 7; set_rd(1, 7); tick();

        // simultaneous issue/clear and double clear on r9
        idle(); iss_en = 1; iss_addr = 9; set_rd(3, 9); tick();
        idle(); iss_en = 1; iss_addr = 9; set_rd(3, 9); wr0_en = 1; wr0_clr = 1; wr0_addr = 9; wr0_data = 64'h9; tick();
        idle(); iss_en = 1; iss_addr = 9; set_rd(3, 9); tick();
        idle(); set_rd(3, 9); wr0_en = 1; wr0_clr = 1; wr0_addr = 9; wr0_data = 64'h90;
        wr1_en = 1; wr1_clr = 1; wr1_addr = 9; wr1_data = 64'h91; iss_addr = 9; tick();
        idle(); set_rd(3, 9); iss_addr = 9; tick();

        for (int c = 0; c < 10000; c++) begin
            reset    = ($urandom_range(0, 799) != 0);
            rd_addr  = NR*AW'($urandom);
            wr0_en   = 1'($urandom_range(0, 1));
            wr0_addr = rnd_addr();
            wr0_data = {$urandom, $urandom};
            wr1_en   = 1'($urandom_range(0, 1));
            wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : rnd_addr();
            wr1_data = {$urandom, $urandom};
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = rnd_addr();
            wr0_clr  = wr0_en && wr0_addr != 0 && cnt[wr0_addr] >= 1 && $urandom_range(0, 1) == 1;
            wr1_clr  = wr1_en && wr1_addr != 0 && $urandom_range(0, 1) == 1 &&
                       cnt[wr1_addr] >= ((wr0_clr && wr0_addr == wr1_addr) ? 2 : 1);
            tick();
        end

        reset = 1'b1;
        idle();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
